// File: rtl/jtag_dmi_master.sv
// JTAG DMI master: drives a target TAP to run RISC-V DMI accesses over the DMI data register.
// Optional busy-retry loop is enabled by defining JTAG_DMI_MASTER_BUSY_RETRY_EN.
module jtag_dmi_master #(
    parameter int unsigned DMI_ADDR_BITS = 6,
    parameter int unsigned DMI_DATA_BITS = 32,
    parameter int unsigned DMI_OP_BITS   = 2,
    parameter int unsigned CLK_DIV       = 4,
    parameter logic [4:0]  IR_DMI        = 5'h11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [DMI_ADDR_BITS-1:0] req_addr_i,
    input  logic [DMI_DATA_BITS-1:0] req_data_i,
    input  logic [DMI_OP_BITS-1:0]   req_op_i,
    output logic                     resp_valid_o,
    output logic [DMI_DATA_BITS-1:0] resp_data_o,
    output logic [DMI_OP_BITS-1:0]   resp_op_o,
    output logic                     jtag_TCK,
    output logic                     jtag_TMS,
    output logic                     jtag_TDI,
    input  logic                     jtag_TDO
);

    localparam int unsigned SCAN_BITS = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
    localparam int unsigned CNT_W     = $clog2(SCAN_BITS + 16);
    localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        TLR_RESET, IDLE, IR_SEL, IR_SHIFT, DR_SEL, DR_SHIFT, EXIT, RESP
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic                     tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [SCAN_BITS-1:0]     sr_q, sr_d;
    logic [DMI_ADDR_BITS-1:0] addr_q, addr_d;
    logic [DMI_DATA_BITS-1:0] data_q, data_d;
    logic                     ir_loaded_q, ir_loaded_d;
    logic                     scan_nop_q, scan_nop_d;
    logic                     exit_dr_q, exit_dr_d;
    logic                     ready_q, ready_d;
    logic                     resp_valid_q, resp_valid_d;
    logic [DMI_DATA_BITS-1:0] resp_data_q, resp_data_d;
    logic [DMI_OP_BITS-1:0]   resp_op_q, resp_op_d;
    logic                     busy_retry, last_bit, bit_start;
    logic [CNT_W-1:0]         exit_last;

`ifdef JTAG_DMI_MASTER_BUSY_RETRY_EN
    assign busy_retry = exit_dr_q && scan_nop_q && (sr_q[DMI_OP_BITS-1:0] == DMI_OP_BITS'(3));
`else
    assign busy_retry = 1'b0;
`endif
    // A busy retry extends EXIT by 8 Run-Test/Idle bits before the next nop scan.
    assign exit_last = busy_retry ? CNT_W'(9) : CNT_W'(1);

    function automatic logic tms_for(input state_e s, input logic [CNT_W-1:0] c);
        case (s)
            TLR_RESET: return c < CNT_W'(5);
            IR_SEL:    return c < CNT_W'(2);
            IR_SHIFT:  return c == CNT_W'(4);
            DR_SEL:    return c == CNT_W'(0);
            DR_SHIFT:  return c == CNT_W'(SCAN_BITS - 1);
            EXIT:      return c == CNT_W'(0);
            default:   return 1'b0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path through the block infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        tck_d        = tck_q;
        tms_d        = tms_q;
        tdi_d        = tdi_q;
        sr_d         = sr_q;
        addr_d       = addr_q;
        data_d       = data_q;
        ir_loaded_d  = ir_loaded_q;
        scan_nop_d   = scan_nop_q;
        exit_dr_d    = exit_dr_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_op_d    = resp_op_q;
        bit_start    = 1'b0;

        case (state_q)
            TLR_RESET: last_bit = (cnt_q == CNT_W'(5));
            IR_SEL:    last_bit = (cnt_q == CNT_W'(3));
            IR_SHIFT:  last_bit = (cnt_q == CNT_W'(4));
            DR_SEL:    last_bit = (cnt_q == CNT_W'(2));
            DR_SHIFT:  last_bit = (cnt_q == CNT_W'(SCAN_BITS - 1));
            EXIT:      last_bit = (cnt_q == exit_last);
            default:   last_bit = 1'b0;
        endcase

        if (state_q == IDLE) begin
            if (req_valid_i && ready_q) begin
                ready_d    = 1'b0;
                addr_d     = req_addr_i;
                data_d     = req_data_i;
                sr_d       = {req_addr_i, req_data_i, req_op_i};
                scan_nop_d = 1'b0;
                cnt_d      = '0;
                div_d      = DIV_RELOAD;
                state_d    = ir_loaded_q ? DR_SEL : IR_SEL;
                bit_start  = 1'b1;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
            ready_d = 1'b1;
        end else if (div_q != '0) begin
            div_d = div_q - 1'b1;
        end else begin
            div_d = DIV_RELOAD;
            tck_d = ~tck_q;
            if (!tck_q) begin
                if (state_q == DR_SHIFT) sr_d = {jtag_TDO, sr_q[SCAN_BITS-1:1]};
            end else begin
                // Falling TCK edge: the current bit is done, set up the next one.
                bit_start = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (last_bit) begin
                    cnt_d = '0;
                    case (state_q)
                        TLR_RESET: begin
                            state_d     = IDLE;
                            ir_loaded_d = 1'b0;
                            ready_d     = 1'b1;
                        end
                        IR_SEL:   state_d = IR_SHIFT;
                        IR_SHIFT: begin
                            state_d   = EXIT;
                            exit_dr_d = 1'b0;
                        end
                        DR_SEL:   state_d = DR_SHIFT;
                        DR_SHIFT: begin
                            state_d   = EXIT;
                            exit_dr_d = 1'b1;
                        end
                        EXIT: begin
                            if (!exit_dr_q) begin
                                ir_loaded_d = 1'b1;
                                state_d     = DR_SEL;
                            end else if (!scan_nop_q || busy_retry) begin
                                scan_nop_d = 1'b1;
                                sr_d       = {addr_q, data_q, {DMI_OP_BITS{1'b0}}};
                                state_d    = DR_SEL;
                            end else begin
                                state_d      = RESP;
                                resp_valid_d = 1'b1;
                                resp_data_d  = sr_q[DMI_OP_BITS +: DMI_DATA_BITS];
                                resp_op_d    = sr_q[DMI_OP_BITS-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        if (bit_start) begin
            tms_d = tms_for(state_d, cnt_d);
            case (state_d)
                IR_SHIFT: tdi_d = IR_DMI[cnt_d[2:0]];
                DR_SHIFT: tdi_d = sr_d[0];
                default:  tdi_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TLR_RESET;
            cnt_q        <= '0;
            div_q        <= DIV_RELOAD;
            tck_q        <= 1'b0;
            tms_q        <= 1'b1;
            tdi_q        <= 1'b0;
            sr_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            ir_loaded_q  <= 1'b0;
            scan_nop_q   <= 1'b0;
            exit_dr_q    <= 1'b0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_op_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the same pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            tck_q        <= tck_d;
            tms_q        <= tms_d;
            tdi_q        <= tdi_d;
            sr_q         <= sr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            ir_loaded_q  <= ir_loaded_d;
            scan_nop_q   <= scan_nop_d;
            exit_dr_q    <= exit_dr_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_op_q    <= resp_op_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_op_o    = resp_op_q;
    assign jtag_TCK     = tck_q;
    assign jtag_TMS     = tms_q;
    assign jtag_TDI     = tdi_q;

endmodule

// File: tb/tb_jtag_dmi_master.sv
// Directed bench for jtag_dmi_master with a behavioural TAP + DMI target model.
module tb_jtag_dmi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [5:0]  req_addr_i = '0;
    logic [31:0] req_data_i = '0;
    logic [1:0]  req_op_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic [1:0]  resp_op_o;
    logic        jtag_TCK, jtag_TMS, jtag_TDI;
    logic        jtag_TDO = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtag_dmi_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_op_i(req_op_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_op_o(resp_op_o),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO)
    );

    // ---------------- TAP / DMI target model ----------------
    typedef enum int {
        T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
        T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
    } tap_e;

    tap_e        tap = T_TLR;
    logic [4:0]  ir = 5'h01;
    logic [4:0]  ir_sh = '0;
    logic [39:0] dr = '0;
    logic        pending = 1'b0;
    int          busy_seen = 0;
    int          busy_cfg = 0;
    logic [31:0] model_data = '0;
    logic [39:0] dr_log[$];
    logic [4:0]  ir_log[$];
    int          resp_pulses = 0;

    function automatic tap_e tap_next(input tap_e s, input logic tms);
        case (s)
            T_TLR:  return tms ? T_TLR  : T_RTI;
            T_RTI:  return tms ? T_SDR  : T_RTI;
            T_SDR:  return tms ? T_SIR  : T_CDR;
            T_CDR:  return tms ? T_E1DR : T_SHDR;
            T_SHDR: return tms ? T_E1DR : T_SHDR;
            T_E1DR: return tms ? T_UDR  : T_PDR;
            T_PDR:  return tms ? T_E2DR : T_PDR;
            T_E2DR: return tms ? T_UDR  : T_SHDR;
            T_UDR:  return tms ? T_SDR  : T_RTI;
            T_SIR:  return tms ? T_TLR  : T_CIR;
            T_CIR:  return tms ? T_E1IR : T_SHIR;
            T_SHIR: return tms ? T_E1IR : T_SHIR;
            T_E1IR: return tms ? T_UIR  : T_PIR;
            T_PIR:  return tms ? T_E2IR : T_PIR;
            T_E2IR: return tms ? T_UIR  : T_SHIR;
            default: return tms ? T_SDR : T_RTI;
        endcase
    endfunction

    always @(posedge jtag_TCK) begin
        case (tap)
            T_TLR: ir = 5'h01;
            T_CDR: begin
                dr = '0;
                if (ir == 5'h11 && pending) begin
                    if (busy_seen < busy_cfg) begin
                        dr = {6'h00, 32'h0, 2'd3};
                        busy_seen++;
                    end else begin
                        dr = {6'h00, model_data, 2'd0};
                        pending = 1'b0;
                        busy_seen = 0;
                    end
                end
            end
            T_SHDR: dr = {jtag_TDI, dr[39:1]};
            T_UDR: if (ir == 5'h11) begin
                dr_log.push_back(dr);
                if (dr[1:0] != 2'd0) pending = 1'b1;
            end
            T_CIR:  ir_sh = 5'h01;
            T_SHIR: ir_sh = {jtag_TDI, ir_sh[4:1]};
            T_UIR: begin
                ir = ir_sh;
                ir_log.push_back(ir_sh);
            end
            default: ;
        endcase
        tap = tap_next(tap, jtag_TMS);
    end

    always @(negedge jtag_TCK)
        jtag_TDO <= (tap == T_SHDR) ? dr[0] : ((tap == T_SHIR) ? ir_sh[0] : 1'b0);

    always @(negedge clk) if (resp_valid_o) resp_pulses++;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic watch_tlr(input string tag);
        int pulses = 0;
        int hi = 0;
        int lo = 0;
        int bad = 0;
        int cyc = 0;
        logic [5:0] tmsv = '0;
        logic prev = 1'b0;
        while (!req_ready_o && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (jtag_TCK) begin
                if (!prev) begin
                    if (pulses < 6) tmsv[pulses] = jtag_TMS;
                    if (pulses > 0 && lo != 4) bad++;
                    pulses++;
                    lo = 0;
                end
                hi++;
            end else begin
                if (prev) begin
                    if (hi != 4) bad++;
                    hi = 0;
                end
                lo++;
            end
            prev = jtag_TCK;
        end
        check({tag, "_pulses"}, 64'(pulses), 64'd6);
        check({tag, "_tms"}, 64'(tmsv), 64'h1f);
        check({tag, "_width_errs"}, 64'(bad), 64'd0);
        check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    endtask

    task automatic do_req(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                          output logic [31:0] rdata, output logic [1:0] rop,
                          output int seen, output int width);
        int n = 0;
        seen = 0;
        width = 0;
        rdata = '0;
        rop = '0;
        while (!req_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        req_valid_i = 1'b1;
        req_addr_i = a;
        req_data_i = d;
        req_op_i = op;
        @(negedge clk);
        req_valid_i = 1'b0;
        n = 0;
        while (!resp_valid_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (resp_valid_o) begin
            seen = 1;
            rdata = resp_data_o;
            rop = resp_op_o;
            while (resp_valid_o && width < 10) begin
                width++;
                @(negedge clk);
            end
        end
    endtask

    function automatic logic [39:0] dr_at(input int idx);
        if (idx < dr_log.size()) return dr_log[idx];
        return 40'hff_ffff_ffff;
    endfunction

    logic [31:0] rd;
    logic [1:0]  rop;
    int seen, width, dr_base, ir_base, pulse_base, n;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tck", 64'(jtag_TCK), 64'd0);
        check("rst_tms", 64'(jtag_TMS), 64'd1);
        check("rst_tdi", 64'(jtag_TDI), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_resp_data", 64'(resp_data_o), 64'd0);
        check("rst_resp_op", 64'(resp_op_o), 64'd0);
        rst_n = 1'b1;
        watch_tlr("tlr0");

        // First write: IR scan, then request + nop DR scans
        model_data = 32'h0;
        do_req(6'h10, 32'h0000_0001, 2'd2, rd, rop, seen, width);
        check("wr_ir_scans", 64'(ir_log.size()), 64'd1);
        check("wr_ir_value", (ir_log.size() > 0) ? 64'(ir_log[0]) : 64'hff, 64'h11);
        check("wr_dr_scans", 64'(dr_log.size()), 64'd2);
        check("wr_dr_req", 64'(dr_at(0)), 64'h40_0000_0006);
        check("wr_dr_nop", 64'(dr_at(1)), 64'h40_0000_0004);
        check("wr_resp_seen", 64'(seen), 64'd1);
        check("wr_resp_width", 64'(width), 64'd1);
        check("wr_resp_op", 64'(rop), 64'd0);

        // Read: IR already loaded
        model_data = 32'hDEAD_BEEF;
        dr_base = dr_log.size();
        do_req(6'h04, 32'h0, 2'd1, rd, rop, seen, width);
        check("rd_ir_scans", 64'(ir_log.size()), 64'd1);
        check("rd_dr_req", 64'(dr_at(dr_base)), 64'h10_0000_0001);
        check("rd_dr_nop", 64'(dr_at(dr_base + 1)), 64'h10_0000_0000);
        check("rd_resp_seen", 64'(seen), 64'd1);
        check("rd_resp_width", 64'(width), 64'd1);
        check("rd_resp_data", 64'(rd), 64'hDEAD_BEEF);
        check("rd_resp_op", 64'(rop), 64'd0);

        // Reset during DR_SHIFT
        pulse_base = resp_pulses;
        req_valid_i = 1'b1;
        req_addr_i = 6'h08;
        req_data_i = 32'hA5A5_A5A5;
        req_op_i = 2'd2;
        @(negedge clk);
        req_valid_i = 1'b0;
        n = 0;
        while (tap != T_SHDR && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_shift", 64'(tap == T_SHDR), 64'd1);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("abort_tck", 64'(jtag_TCK), 64'd0);
        check("abort_tms", 64'(jtag_TMS), 64'd1);
        check("abort_ready", 64'(req_ready_o), 64'd0);
        check("abort_resp_valid", 64'(resp_valid_o), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        watch_tlr("tlr1");
        check("abort_no_resp", 64'(resp_pulses - pulse_base), 64'd0);
        ir_base = ir_log.size();
        model_data = 32'h0BAD_F00D;
        do_req(6'h04, 32'h0, 2'd1, rd, rop, seen, width);
        check("post_rst_ir_scan", 64'(ir_log.size() - ir_base), 64'd1);
        check("post_rst_resp_seen", 64'(seen), 64'd1);
        check("post_rst_resp_data", 64'(rd), 64'h0BAD_F00D);

        // Busy: target answers op 3 twice, then ok
        model_data = 32'h1234_5678;
        busy_cfg = 2;
        dr_base = dr_log.size();
        do_req(6'h05, 32'h0, 2'd1, rd, rop, seen, width);
        check("busy_resp_seen", 64'(seen), 64'd1);
        check("busy_resp_width", 64'(width), 64'd1);
`ifdef JTAG_DMI_MASTER_BUSY_RETRY_EN
        check("busy_dr_scans", 64'(dr_log.size() - dr_base), 64'd4);
        check("busy_resp_op", 64'(rop), 64'd0);
        check("busy_resp_data", 64'(rd), 64'h1234_5678);
`else
        check("busy_dr_scans", 64'(dr_log.size() - dr_base), 64'd2);
        check("busy_resp_op", 64'(rop), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_dmi_master.md
JTAG_DMI_MASTER -- requirements
Module: jtag_dmi_master

Interface
REQ-001 SHALL have parameter DMI_ADDR_BITS, default 6, the DMI address width.
REQ-002 SHALL have parameter DMI_DATA_BITS, default 32, the DMI data width.
REQ-003 SHALL have parameter DMI_OP_BITS, default 2, the DMI op/status width.
REQ-004 SHALL have parameter CLK_DIV, default 4, the TCK half-period in clk cycles (legal values 1 to 255).
REQ-005 SHALL have parameter IR_DMI, default 5'h11, the IR value selecting the DMI register.
REQ-006 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n; no other clock or reset.
REQ-007 clk  input  1  system clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 req_valid_i  input  1  DMI request present.
REQ-010 req_ready_o  output  1  high when a request is accepted this cycle.
REQ-011 req_addr_i  input  DMI_ADDR_BITS  request address.
REQ-012 req_data_i  input  DMI_DATA_BITS  request write data.
REQ-013 req_op_i  input  DMI_OP_BITS  request op (0 nop, 1 read, 2 write).
REQ-014 resp_valid_o  output  1  one-cycle pulse with the response.
REQ-015 resp_data_o  output  DMI_DATA_BITS  returned data.
REQ-016 resp_op_o  output  DMI_OP_BITS  returned status (0 ok, 2 failed, 3 busy).
REQ-017 jtag_TCK  output  1  JTAG clock to the target TAP.
REQ-018 jtag_TMS  output  1  JTAG mode select.
REQ-019 jtag_TDI  output  1  JTAG data to the target.
REQ-020 jtag_TDO  input  1  JTAG data from the target.

Function
REQ-021 Each TCK bit SHALL hold TCK low for CLK_DIV clk cycles, then high for CLK_DIV cycles; TMS/TDI change only on the clk edge that drives TCK low; TDO is sampled on the clk edge that drives TCK high.
REQ-022 FSM states SHALL be TLR_RESET, IDLE, IR_SEL, IR_SHIFT, DR_SEL, DR_SHIFT, EXIT, RESP.
REQ-023 TLR_RESET SHALL clock 5 bits with TMS=1, then 1 bit with TMS=0 (Run-Test/Idle), clear the ir_loaded flag, and go to IDLE.
REQ-024 IDLE SHALL hold TCK low and TMS 0; req_ready_o=1 only in IDLE with no response pending; acceptance = req_valid_i && req_ready_o, which latches addr/data/op.
REQ-025 After acceptance, if ir_loaded=0: IR_SEL clocks TMS 1,1,0,0; IR_SHIFT shifts 5 bits of IR_DMI LSB first, TMS=1 on the last bit; EXIT clocks TMS 1,0; then ir_loaded=1. If ir_loaded=1, the IR scan is skipped.
REQ-026 DR_SEL SHALL clock TMS 1,0,0; DR_SHIFT shifts {addr,data,op} (DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS bits) LSB first, TMS=1 on the last bit; EXIT clocks TMS 1,0 back to Run-Test/Idle.
REQ-027 The request scan SHALL be followed by a second DR scan with op=0, addr and data unchanged; the TDO bits captured in that scan form the response.
REQ-028 Captured bits [DMI_OP_BITS-1:0] SHALL drive resp_op_o and the next DMI_DATA_BITS bits SHALL drive resp_data_o; resp_valid_o pulses for exactly one clk in RESP, then the FSM returns to IDLE.
REQ-029 Responses SHALL be in request order with exactly one response per accepted request; req_valid_i is ignored outside IDLE.
REQ-030 Bit and divider counters SHALL be sized for the scan length and CLK_DIV with no wrap inside a scan; the divider reloads at every TCK edge.

Reset
REQ-031 On rst_n low: jtag_TCK=0, jtag_TMS=1, jtag_TDI=0, req_ready_o=0, resp_valid_o=0, resp_data_o=0, resp_op_o=0, ir_loaded=0, state=TLR_RESET.
REQ-032 Reset asserted mid-scan SHALL abort immediately with no response; after release the TLR_RESET sequence runs before any request is accepted.

Configuration
REQ-033 With JTAG_DMI_MASTER_BUSY_RETRY_EN defined: a captured op of 3 SHALL trigger another op=0 DR scan after 8 idle TCK cycles, repeated until op is not 3, and then respond; without it, op 3 SHALL be returned directly in resp_op_o.

Verification
REQ-034 Reset release, CLK_DIV=4 -> 6 TCK pulses (TMS 1,1,1,1,1,0) of 8 clk each; req_ready_o rises afterward.
REQ-035 First write addr 0x10, data 0x00000001 -> IR shifts 0x11, then a 40-bit DR scan of 0x4000000006 LSB first, then a nop scan; model returns op 0 -> resp_op_o=0, one-cycle resp_valid_o.
REQ-036 Second request, read addr 0x04, model data 0xDEADBEEF -> no IR scan; resp_data_o=0xDEADBEEF, resp_op_o=0.
REQ-037 Model returns op 3 twice then 0 -> with macro: 3 nop scans, a single response with op 0; without macro: response op 3 after the first nop scan.
REQ-038 rst_n pulsed low during DR_SHIFT -> outputs at reset values, no resp_valid_o, TLR sequence repeated, and the next request includes the IR scan.
